// File: rtl/soc_system_sysid_ext_if.sv
// -----------------------------------------------------------------------------
// soc_system_sysid_ext_if
// Avalon-MM slave bundle for the system-identification block.
//   address        word address, ADDR_W bits      (master -> slave)
//   read / write   request strobes                (master -> slave)
//   writedata      32-bit write data              (master -> slave)
//   readdata       32-bit read data               (slave -> master)
//   readdatavalid  read-response strobe           (slave -> master)
// There is no waitrequest: the slave accepts every request in its own cycle.
// -----------------------------------------------------------------------------
interface soc_system_sysid_ext_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output readdatavalid
  );

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  readdatavalid
  );
endinterface

// File: rtl/soc_system_sysid_ext.sv
// -----------------------------------------------------------------------------
// soc_system_sysid_ext
// System-identification slave: ID and build-timestamp words, a table of
// build-info words, a software scratch register, and a free-running 64-bit
// uptime counter whose high word is captured into a snapshot whenever the low
// word is read, so software sees both halves from one counter sample.
// Read data is returned through a fixed-latency pipeline of READ_LATENCY
// stages and flagged by readdatavalid.
//
// Ports:
//   clock    single clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address/read/write/writedata in,
//            readdata/readdatavalid out)
//
// Word map: 0 ID, 1 timestamp, 2 scratch (rw), 3 uptime low (write clears),
//           4 uptime high snapshot, 5 capability, 6.. info words, others 0.
//
// UPTIME_INIT is the counter reset value; it stays 0 in a real system and only
// exists so a simulation can start near a wrap point.
// -----------------------------------------------------------------------------
module soc_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'hACD5_1302,
  parameter logic [31:0] TIMESTAMP    = 32'h5430_5DB9,
  parameter int          NUM_INFO     = 2,
  parameter logic [(NUM_INFO > 0 ? 32*NUM_INFO : 32)-1:0] INFO_WORDS = '0,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          READ_LATENCY = 1,
  parameter int          ADDR_W       = 5,
  parameter logic [63:0] UPTIME_INIT  = 64'h0000_0000_0000_0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  soc_system_sysid_ext_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UPTIME  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_SNAP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CAP     = ADDR_W'(5);
  localparam int                INFO_BASE = 6;

  localparam logic [31:0] CAPABILITY = {8'h00, 8'(NUM_INFO), 12'h000, 4'(READ_LATENCY)};

  // request decode
  logic        rd_acc_s;
  logic        wr_acc_s;
  logic [31:0] addr_ext_s;
  logic [31:0] rdata_s;

  // register state
  logic [31:0] scratch_q, scratch_d;
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] snap_q, snap_d;

  // read pipeline, stage 0 is loaded at the acceptance edge
  logic [READ_LATENCY-1:0]       pipe_v_q, pipe_v_d;
  logic [READ_LATENCY-1:0][31:0] pipe_d_q, pipe_d_d;

  // A simultaneous read wins; the write in that cycle is dropped.
  assign rd_acc_s   = bus.read;
  assign wr_acc_s   = bus.write & ~bus.read;
  assign addr_ext_s = 32'(bus.address);

  // Read-data mux over the register map, from state before the acceptance edge
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (bus.address)
      A_ID:      rdata_s = ID_VALUE;
      A_TSTAMP:  rdata_s = TIMESTAMP;
      A_SCRATCH: rdata_s = scratch_q;
      A_UPTIME:  rdata_s = uptime_q[31:0];
      A_SNAP:    rdata_s = snap_q;
      A_CAP:     rdata_s = CAPABILITY;
      default: begin
        // info table; unmapped addresses keep the 0 default
        for (int k = 0; k < NUM_INFO; k++) begin
          rdata_s = (addr_ext_s == 32'(INFO_BASE + k)) ? INFO_WORDS[32*k +: 32] : rdata_s;
        end
      end
    endcase
  end

  // Next-state for scratch, uptime counter and snapshot
  always_comb begin
    scratch_d = scratch_q;
    uptime_d  = uptime_q + 64'd1;
    snap_d    = snap_q;

    if (wr_acc_s && (bus.address == A_SCRATCH)) begin
      scratch_d = bus.writedata;
    end else begin
      scratch_d = scratch_q;
    end

    // a write to the uptime word makes the counter read 0 in the next cycle
    if (wr_acc_s && (bus.address == A_UPTIME)) begin
      uptime_d = 64'h0000_0000_0000_0000;
    end else begin
      uptime_d = uptime_q + 64'd1;
    end

    // capture the high word from the same sample the low-word read returns
    if (rd_acc_s && (bus.address == A_UPTIME)) begin
      snap_d = uptime_q[63:32];
    end else begin
      snap_d = snap_q;
    end
  end

  // Register state update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= SCRATCH_INIT;
      uptime_q  <= UPTIME_INIT;
      snap_q    <= 32'h0000_0000;
    end else begin
      scratch_q <= scratch_d;
      uptime_q  <= uptime_d;
      snap_q    <= snap_d;
    end
  end

  // Read pipeline shift: stage 0 takes the new response, later stages follow
  always_comb begin
    pipe_v_d    = pipe_v_q;
    pipe_d_d    = pipe_d_q;
    pipe_v_d[0] = rd_acc_s;
    pipe_d_d[0] = rd_acc_s ? rdata_s : 32'h0000_0000;
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_v_d[s] = pipe_v_q[s-1];
      pipe_d_d[s] = pipe_d_q[s-1];
    end
  end

  // Read pipeline registers; reset discards anything in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v_q <= '0;
      pipe_d_q <= '0;
    end else begin
      pipe_v_q <= pipe_v_d;
      pipe_d_q <= pipe_d_d;
    end
  end

  assign bus.readdatavalid = pipe_v_q[READ_LATENCY-1];
  assign bus.readdata      = pipe_d_q[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// -----------------------------------------------------------------------------
// tb_soc_system_sysid_ext
// Two instances driven with identical bus traffic:
//   dut_a  default parameters (NUM_INFO=2, READ_LATENCY=1)
//   dut_b  NUM_INFO=3, READ_LATENCY=3, info words 1,2,3, non-zero scratch
//          reset value, counter starting just below the 32-bit wrap
// A reference model holds the register contents as plain variables and
// schedules each expected response into a slot keyed by the cycle it is due.
// -----------------------------------------------------------------------------
module tb_soc_system_sysid_ext;

  localparam logic [31:0] ID_W  = 32'hACD5_1302;
  localparam logic [31:0] TS_W  = 32'h5430_5DB9;
  localparam logic [31:0] B_SCR = 32'hC0FF_EE00;
  localparam logic [63:0] B_UP  = 64'h0000_0000_FFFF_FFF0;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  soc_system_sysid_ext_if #(.ADDR_W(5)) bus_a ();
  soc_system_sysid_ext_if #(.ADDR_W(5)) bus_b ();

  soc_system_sysid_ext dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  soc_system_sysid_ext #(
    .NUM_INFO     (3),
    .INFO_WORDS   (96'h00000003_00000002_00000001),
    .SCRATCH_INIT (B_SCR),
    .READ_LATENCY (3),
    .ADDR_W       (5),
    .UPTIME_INIT  (B_UP)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  // reference model state, index 0 = dut_a, 1 = dut_b
  logic [63:0] cnt_m  [2];
  logic [31:0] scr_m  [2];
  logic [31:0] snap_m [2];
  logic        exp_v  [2][8];
  logic [31:0] exp_d  [2][8];
  int          edge_n;
  int          n_tests;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ni(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int rl(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] model_read(input int i, input int a);
    if (a == 0) return ID_W;
    if (a == 1) return TS_W;
    if (a == 2) return scr_m[i];
    if (a == 3) return cnt_m[i][31:0];
    if (a == 4) return snap_m[i];
    if (a == 5) return 32'(ni(i) * 65536 + rl(i));
    if (a >= 6 && a < 6 + ni(i)) return (i == 0) ? 32'h0 : 32'(a - 5);
    return 32'h0;
  endfunction

  task automatic model_reset();
    cnt_m[0]  = 64'h0;
    cnt_m[1]  = B_UP;
    scr_m[0]  = 32'h0;
    scr_m[1]  = B_SCR;
    snap_m[0] = 32'h0;
    snap_m[1] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 8; s++) begin
        exp_v[i][s] = 1'b0;
        exp_d[i][s] = 32'h0;
      end
    end
  endtask

  // Called at a falling edge: check this cycle's outputs, drive the next
  // request, advance the model across the coming rising edge.
  task automatic step(input int a, input logic rd, input logic wr, input logic [31:0] wd);
    int          slot;
    logic        gv;
    logic [31:0] gd;
    slot = edge_n % 8;
    for (int i = 0; i < 2; i++) begin
      gv = (i == 0) ? bus_a.readdatavalid : bus_b.readdatavalid;
      gd = (i == 0) ? bus_a.readdata : bus_b.readdata;
      check_eq($sformatf("valid_%0d", i), {31'h0, gv}, {31'h0, exp_v[i][slot]});
      if (exp_v[i][slot]) check_eq($sformatf("data_%0d", i), gd, exp_d[i][slot]);
      exp_v[i][slot] = 1'b0;
    end
    bus_a.address = 5'(a); bus_a.read = rd; bus_a.write = wr; bus_a.writedata = wd;
    bus_b.address = 5'(a); bus_b.read = rd; bus_b.write = wr; bus_b.writedata = wd;
    for (int i = 0; i < 2; i++) begin
      if (rd) begin
        exp_v[i][(edge_n + rl(i)) % 8] = 1'b1;
        exp_d[i][(edge_n + rl(i)) % 8] = model_read(i, a);
        if (a == 3) snap_m[i] = cnt_m[i][63:32];
      end
      if (wr && !rd && a == 3) cnt_m[i] = 64'h0;
      else                     cnt_m[i] = cnt_m[i] + 64'd1;
      if (wr && !rd && a == 2) scr_m[i] = wd;
    end
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  task automatic rd_word(input int a);
    step(a, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic wr_word(input int a, input logic [31:0] d);
    step(a, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int          a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    n_tests = 0;
    n_fail  = 0;
    edge_n  = 0;
    bus_a.address = '0; bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.writedata = 32'h0;
    bus_b.address = '0; bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.writedata = 32'h0;
    model_reset();

    // reset state
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_valid_a", {31'h0, bus_a.readdatavalid}, 32'h0);
    check_eq("rst_valid_b", {31'h0, bus_b.readdatavalid}, 32'h0);
    check_eq("rst_data_a", bus_a.readdata, 32'h0);
    check_eq("rst_data_b", bus_b.readdata, 32'h0);
    reset_n = 1'b1;

    // first-cycle counter, then ID / timestamp / capability back-to-back
    rd_word(3);
    rd_word(0);
    rd_word(1);
    rd_word(5);

    // run dut_b up to the 32-bit wrap, read low then high words
    for (int n = 0; n < 64 && cnt_m[1][31:0] != 32'hFFFF_FFFF; n++) idle(1);
    rd_word(3);
    rd_word(4);
    idle(3);
    rd_word(4);
    rd_word(3);
    rd_word(4);
    idle(2);
    rd_word(4);

    // scratch write/read, and read+write collision dropping the write
    wr_word(2, 32'hDEAD_BEEF);
    rd_word(2);
    step(2, 1'b1, 1'b1, 32'h0000_1234);
    rd_word(2);

    // counter clear, read two cycles after the write
    wr_word(3, 32'h5555_AAAA);
    idle(1);
    rd_word(3);
    rd_word(4);

    // info table, unmapped addresses, writes to read-only words
    rd_word(6); rd_word(7); rd_word(8); rd_word(9); rd_word(31);
    wr_word(0, 32'h1111_1111); wr_word(1, 32'h2222_2222); wr_word(6, 32'h3333_3333);
    wr_word(31, 32'h4444_4444);
    rd_word(0); rd_word(1); rd_word(6); rd_word(31);

    // randomized traffic, biased toward mapped addresses
    for (int n = 0; n < 500; n++) begin
      a  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 31));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      step(a, rd, wr, wd);
    end
    idle(6);

    // asynchronous reset with reads in flight
    wr_word(2, 32'hDEAD_BEEF);
    rd_word(2);
    rd_word(2);
    idle(1);
    check_eq("pre_rst_valid_b", {31'h0, bus_b.readdatavalid}, {31'h0, exp_v[1][edge_n % 8]});
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid_a", {31'h0, bus_a.readdatavalid}, 32'h0);
    check_eq("async_rst_valid_b", {31'h0, bus_b.readdatavalid}, 32'h0);
    check_eq("async_rst_data_b", bus_b.readdata, 32'h0);
    model_reset();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    reset_n = 1'b1;
    idle(5);
    rd_word(4);
    rd_word(2);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
